// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared single-port program/data memory between the CPU and the debug/loader port.
// Build option: define MEM_ARB_STARVE_GUARD_EN to force a debug grant after STARVE_MAX lost cycles.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_strobe,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {ArbIdle, ArbCpu, ArbDbg, ArbLocked} arb_state_e;

  arb_state_e        state_q, state_d;
  logic              cpu_rvalid_q, dbg_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              starve_fire;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);
  logic [7:0] starve_cnt_q;

  assign starve_fire = (starve_cnt_q >= StarveMax);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_q <= '0;
    end else if (!dbg_req || dbg_gnt) begin
      starve_cnt_q <= '0;
    end else if (starve_cnt_q < StarveMax) begin
      starve_cnt_q <= starve_cnt_q + 8'd1;
    end
  end
`else
  assign starve_fire = 1'b0;
`endif

  // Grants are forced low while reset is asserted so nothing reaches the memory.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (reset_n) begin
      if (state_q == ArbLocked) begin
        dbg_gnt = dbg_req;
      end else if (dbg_req && (!cpu_req || starve_fire)) begin
        dbg_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
      end
    end
  end

  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_strobe = 1'b0;
    mem_we     = 1'b0;
    if (cpu_gnt) begin
      mem_addr   = cpu_addr;
      mem_strobe = 1'b1;
    end else if (dbg_gnt) begin
      mem_addr = dbg_addr;
      if (dbg_we) begin
        mem_we    = 1'b1;
        mem_wdata = dbg_wdata;
      end else begin
        mem_strobe = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ArbLocked) begin
      if (!dbg_lock) state_d = ArbIdle;
    end else if (cpu_gnt) begin
      state_d = ArbCpu;
    end else if (dbg_gnt) begin
      state_d = dbg_lock ? ArbLocked : ArbDbg;
    end else begin
      state_d = ArbIdle;
    end
  end

  // The rvalid pair doubles as the owner tag routing the next-cycle read response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ArbIdle;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cpu_rvalid_q <= cpu_gnt;
      dbg_rvalid_q <= dbg_gnt && !dbg_we;
      if (cpu_rvalid_q) cpu_rdata_q <= mem_rdata;
      if (dbg_rvalid_q) dbg_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata  = dbg_rvalid_q ? mem_rdata : dbg_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural registered-read memory.
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cpu_req, cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_addr, cpu_rdata;
  logic       dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [7:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_strobe, mem_we;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem [256] = '{default: 8'h00};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_strobe) mem_rdata <= mem[mem_addr];
  end

  mem_bus_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_lock   (dbg_lock),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_addr   (mem_addr),
    .mem_strobe (mem_strobe),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  logic [7:0] pre_addr [3];
  logic [7:0] pre_data [3];

  initial begin
    pre_addr[0] = 8'h10; pre_data[0] = 8'hC5;
    pre_addr[1] = 8'h01; pre_data[1] = 8'h11;
    pre_addr[2] = 8'h02; pre_data[2] = 8'h22;

    reset_n = 1'b0; cpu_req = 1'b1; cpu_addr = 8'h10;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00; dbg_lock = 1'b0;
    repeat (2) tick();
    settle();
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_mem_strobe", mem_strobe, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);

    // Grant pending, then reset hits before the clock edge.
    tick();
    reset_n = 1'b1;
    settle();
    check("pend_cpu_gnt", cpu_gnt, 1);
    reset_n = 1'b0;
    #1;
    check("pend_rst_gnt", cpu_gnt, 0);
    check("pend_rst_strobe", mem_strobe, 0);
    tick();
    cpu_req = 1'b0;
    reset_n = 1'b1;
    settle();
    check("post_rst_rvalid0", cpu_rvalid, 0);
    tick();
    settle();
    check("post_rst_rvalid1", cpu_rvalid, 0);
    check("post_rst_dbg_rvalid", dbg_rvalid, 0);
    tick();

    for (int i = 0; i < 3; i++) begin
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = pre_addr[i]; dbg_wdata = pre_data[i];
      settle();
      check("wr_gnt", dbg_gnt, 1);
      check("wr_mem_we", mem_we, 1);
      check("wr_strobe", mem_strobe, 0);
      check("wr_addr", mem_addr, pre_addr[i]);
      check("wr_wdata", mem_wdata, pre_data[i]);
      check("wr_no_rvalid", dbg_rvalid, 0);
      tick();
    end
    dbg_req = 1'b0; dbg_we = 1'b0;
    settle();
    check("wr_last_no_rvalid", dbg_rvalid, 0);
    tick();

    cpu_req = 1'b1; cpu_addr = 8'h10;
    settle();
    check("rd_cpu_gnt", cpu_gnt, 1);
    check("rd_strobe", mem_strobe, 1);
    check("rd_addr", mem_addr, 8'h10);
    check("rd_dbg_gnt", dbg_gnt, 0);
    tick();
    cpu_req = 1'b0;
    settle();
    check("rd_rvalid", cpu_rvalid, 1);
    check("rd_rdata", cpu_rdata, 8'hC5);
    check("rd_dbg_rvalid", dbg_rvalid, 0);
    tick();
    settle();
    check("rd_rvalid_drop", cpu_rvalid, 0);
    check("rd_rdata_hold", cpu_rdata, 8'hC5);
    tick();

    // Conflict followed by back-to-back responses.
    cpu_req = 1'b1; cpu_addr = 8'h01;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h02;
    settle();
    check("cf_cpu_gnt", cpu_gnt, 1);
    check("cf_dbg_gnt", dbg_gnt, 0);
    tick();
    cpu_req = 1'b0;
    settle();
    check("cf_dbg_gnt_next", dbg_gnt, 1);
    check("cf_dbg_addr", mem_addr, 8'h02);
    check("b2b_cpu_rvalid", cpu_rvalid, 1);
    check("b2b_cpu_rdata", cpu_rdata, 8'h11);
    check("b2b_dbg_rvalid0", dbg_rvalid, 0);
    tick();
    dbg_req = 1'b0;
    settle();
    check("b2b_dbg_rvalid", dbg_rvalid, 1);
    check("b2b_dbg_rdata", dbg_rdata, 8'h22);
    check("b2b_cpu_rvalid0", cpu_rvalid, 0);
    check("b2b_cpu_hold", cpu_rdata, 8'h11);
    tick();

    // A lock with no debug request must not block the CPU.
    cpu_req = 1'b1; cpu_addr = 8'h02; dbg_lock = 1'b1;
    settle();
    check("nolock_gnt0", cpu_gnt, 1);
    tick();
    settle();
    check("nolock_gnt1", cpu_gnt, 1);
    tick();
    cpu_req = 1'b0; dbg_lock = 1'b0;
    tick();

    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 8'hA5; dbg_lock = 1'b1;
    settle();
    check("lk_dbg_gnt", dbg_gnt, 1);
    check("lk_mem_we", mem_we, 1);
    check("lk_wdata", mem_wdata, 8'hA5);
    check("lk_addr", mem_addr, 8'h20);
    tick();
    dbg_req = 1'b0; dbg_we = 1'b0; cpu_req = 1'b1; cpu_addr = 8'h20;
    settle();
    check("lk_hold1", cpu_gnt, 0);
    check("lk_hold1_strobe", mem_strobe, 0);
    tick();
    settle();
    check("lk_hold2", cpu_gnt, 0);
    tick();
    dbg_lock = 1'b0;
    settle();
    check("lk_release_cycle", cpu_gnt, 0);
    tick();
    settle();
    check("lk_cpu_gnt", cpu_gnt, 1);
    check("lk_cpu_addr", mem_addr, 8'h20);
    tick();
    cpu_req = 1'b0;
    settle();
    check("lk_rd_rvalid", cpu_rvalid, 1);
    check("lk_rd_rdata", cpu_rdata, 8'hA5);
    tick();

    cpu_req = 1'b1; cpu_addr = 8'h01;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h02;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 4; i++) begin
      settle();
      check("sv_wait_dbg", dbg_gnt, 0);
      check("sv_wait_cpu", cpu_gnt, 1);
      tick();
    end
    settle();
    check("sv_fire_dbg", dbg_gnt, 1);
    check("sv_fire_cpu", cpu_gnt, 0);
    tick();
    dbg_req = 1'b0;
    settle();
    check("sv_dbg_rvalid", dbg_rvalid, 1);
    check("sv_dbg_rdata", dbg_rdata, 8'h22);
    check("sv_cpu_rvalid", cpu_rvalid, 0);
    check("sv_cpu_back", cpu_gnt, 1);
    tick();
    dbg_req = 1'b1;
    settle();
    check("sv_cnt_cleared", dbg_gnt, 0);
    tick();
`else
    for (int i = 0; i < 6; i++) begin
      settle();
      check("sv_off_dbg", dbg_gnt, 0);
      check("sv_off_cpu", cpu_gnt, 1);
      tick();
    end
`endif
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
